unidade_controle_multiciclo: RTL
================================

Name: unidade_controle_multiciclo

Overview:
Multi-cycle main control FSM for the processor datapath. It sequences fetch, decode, execute, memory and writeback for one instruction at a time. It drives the 2-bit OpAlu class into the ALU control decoder and generates the mux selects and write enables for the PC, IR, register file and memory. It handshakes with memory through a ready signal and has a wait timeout, a retired-instruction counter and sticky error flags.

Parameters:
TIMEOUT_MEM, 255, number of consecutive cycles a memory wait state may spend without mem_pronta before a memory error is raised (must be at least 1).
LARGURA_CONT, 32, width of the retired-instruction counter.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
Opcode  in  6  opcode field of the IR (valid from DECODIFICA onward).
Zero  in  1  ALU zero flag.
mem_pronta  in  1  memory ready; completes the current read or write this cycle.
OpAlu  out  2  ALU class: 00 = add, 01 = subtract, 10 = function taken from Opcode.
alu_fonte_a  out  1  ALU A select: 0 = PC, 1 = register A.
alu_fonte_b  out  2  ALU B select: 00 = register B, 01 = constant 1, 10 = sign-extended immediate, 11 = branch offset.
pc_fonte  out  2  PC source: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
pc_escreve  out  1  PC write enable.
ir_escreve  out  1  IR write enable.
mem_le  out  1  memory read request.
mem_escreve  out  1  memory write request.
reg_escreve  out  1  register file write enable.
mem_para_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
estado  out  4  current state encoding (debug).
instrucoes  out  LARGURA_CONT  count of retired instructions.
parado  out  1  high while in PARADO.
erro_opcode  out  1  sticky flag: an illegal opcode was decoded.
erro_mem  out  1  sticky flag: a memory wait timed out.

Behaviour:
- Reset (asynchronous, active-high): state = BUSCA, wait counter = 0, instrucoes = 0, erro_opcode = 0, erro_mem = 0.
- While reset is high, every control output is forced to 0. estado reads 0.
- State encodings: BUSCA=0, DECODIFICA=1, EXEC_R=2, ESCRITA_R=3, CALC_END=4, LE_MEM=5, ESCRITA_MEM=6, GRAVA_MEM=7, DESVIO=8, SALTO=9, PARADO=10.
- Any unused encoding goes to PARADO on the next edge.
- Control outputs not listed for a state are 0.
- BUSCA:
  - Outputs: mem_le=1, alu_fonte_a=0, alu_fonte_b=01, OpAlu=00.
  - ir_escreve and pc_escreve equal mem_pronta (Mealy), with pc_fonte=00.
  - Stays in BUSCA until mem_pronta, then goes to DECODIFICA.
- DECODIFICA:
  - Outputs: alu_fonte_a=0, alu_fonte_b=11, OpAlu=00 (precomputes the branch target into ALUOut).
  - Next state by Opcode:
    - ALU set {000101, 000111, 001011, 001100, 001101, 001110, 001111, 010000, 010001, 010010, 010011, 010110} -> EXEC_R.
    - 000001 (load) or 000010 (store) -> CALC_END.
    - 000011 (beq) -> DESVIO.
    - 000100 (jump) -> SALTO.
    - 000000 (nop) -> BUSCA; counts as retired.
    - 111111 (halt) -> PARADO; counts as retired.
    - Any other opcode -> PARADO and sets erro_opcode.
- EXEC_R: alu_fonte_a=1, alu_fonte_b=00, OpAlu=10. Next state ESCRITA_R.
- ESCRITA_R: reg_escreve=1, mem_para_reg=0. Next state BUSCA; retires the instruction.
- CALC_END: alu_fonte_a=1, alu_fonte_b=10, OpAlu=00. Next state LE_MEM for a load, GRAVA_MEM for a store.
- LE_MEM: mem_le=1. Goes to ESCRITA_MEM on mem_pronta.
- ESCRITA_MEM: reg_escreve=1, mem_para_reg=1. Next state BUSCA; retires.
- GRAVA_MEM: mem_escreve=1. Goes to BUSCA on mem_pronta; retires.
- DESVIO:
  - Outputs: alu_fonte_a=1, alu_fonte_b=00, OpAlu=01, pc_fonte=01, pc_escreve=Zero.
  - Next state BUSCA; retires whether or not the branch is taken.
- SALTO: pc_fonte=10, pc_escreve=1. Next state BUSCA; retires.
- PARADO: parado=1, all other controls 0. Stays in PARADO until reset.
- Wait timeout (applies in BUSCA, LE_MEM and GRAVA_MEM):
  - The wait counter increments each cycle mem_pronta=0 and clears on mem_pronta or on any state change.
  - If the counter reaches TIMEOUT_MEM with mem_pronta=0, the FSM goes to PARADO and sets erro_mem.
  - If mem_pronta arrives in the same cycle the limit is reached, the handshake completes and no error is raised.
- Retirement: instrucoes increments by 1 on the edge that retires an instruction and wraps modulo 2^LARGURA_CONT.
- Error flags hold until reset.

Decomposition:
- Shared package (controle_pkg): state encodings; opcode constants (OP_NOP, OP_LOAD, OP_STORE, OP_BEQ, OP_JUMP, OP_HALT); OpAlu class constants; alu_fonte_b and pc_fonte select constants; a function eh_op_alu(opcode) for the ALU-set membership check.
- One natural sub-module: temporizador_espera_mem, the wait counter plus timeout compare.

Test Plan:
- Reset, then R-type Opcode=000101 with mem_pronta=1 in the first BUSCA cycle -> states 0,1,2,3,0. OpAlu is 10 in EXEC_R. reg_escreve=1 for exactly 1 cycle. instrucoes=1.
- Load (000001) with mem_pronta delayed 3 cycles in LE_MEM -> LE_MEM held 4 cycles. mem_para_reg=1 and reg_escreve=1 in ESCRITA_MEM. instrucoes increments by 1.
- beq (000011) with Zero=1, then again with Zero=0 -> pc_escreve=1 with pc_fonte=01 the first time, pc_escreve=0 the second. Both retire, so instrucoes increases by 2.
- Illegal Opcode=111000 -> PARADO next edge. erro_opcode=1, parado=1, all enables 0. The FSM stays in PARADO for 20 cycles, then reset clears everything.
- TIMEOUT_MEM=4, mem_pronta held at 0 in BUSCA -> after 4 waiting cycles the FSM enters PARADO and erro_mem=1. Repeat with mem_pronta=1 on the 4th cycle -> DECODIFICA and no error.
- Assert reset asynchronously mid-GRAVA_MEM -> mem_escreve drops immediately without a clock edge. estado=0 after reset; instrucoes and the error flags are cleared.

Source files
------------

// File: rtl/controle_pkg.sv
// controle_pkg: shared definitions for the multi-cycle main control unit.
// Holds the state encodings, opcode constants, ALU class and mux select
// codes, the packed control word driven toward the datapath, and the
// ALU-opcode membership check used in decode.
package controle_pkg;

    typedef enum logic [3:0] {
        BUSCA       = 4'd0,
        DECODIFICA  = 4'd1,
        EXEC_R      = 4'd2,
        ESCRITA_R   = 4'd3,
        CALC_END    = 4'd4,
        LE_MEM      = 4'd5,
        ESCRITA_MEM = 4'd6,
        GRAVA_MEM   = 4'd7,
        DESVIO      = 4'd8,
        SALTO       = 4'd9,
        PARADO      = 4'd10
    } estado_t;

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_LOAD  = 6'b000001;
    localparam logic [5:0] OP_STORE = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000011;
    localparam logic [5:0] OP_JUMP  = 6'b000100;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] ALU_SOMA = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] FB_REG_B  = 2'b00;
    localparam logic [1:0] FB_UM     = 2'b01;
    localparam logic [1:0] FB_IMED   = 2'b10;
    localparam logic [1:0] FB_DESVIO = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SALTO  = 2'b10;

    // Everything the FSM drives toward the datapath, so it can be
    // defaulted and forced to zero in one assignment.
    typedef struct packed {
        logic [1:0] op_alu;
        logic       alu_fonte_a;
        logic [1:0] alu_fonte_b;
        logic [1:0] pc_fonte;
        logic       pc_escreve;
        logic       ir_escreve;
        logic       mem_le;
        logic       mem_escreve;
        logic       reg_escreve;
        logic       mem_para_reg;
        logic       parado;
    } ctrl_t;

    // Opcodes executed as register-register ALU operations.
    function automatic logic eh_op_alu(input logic [5:0] opcode);
        case (opcode)
            6'b000101, 6'b000111, 6'b001011, 6'b001100,
            6'b001101, 6'b001110, 6'b001111, 6'b010000,
            6'b010001, 6'b010010, 6'b010011, 6'b010110: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// unidade_controle_multiciclo_if: control/handshake bundle between the main
// control FSM (master) and the datapath plus memory (slave).
//   Opcode, Zero, mem_pronta      : datapath/memory -> control
//   OpAlu, alu_fonte_a/b, pc_*,
//   ir_escreve, mem_le/escreve,
//   reg_escreve, mem_para_reg     : control -> datapath/memory
interface unidade_controle_multiciclo_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       mem_pronta;
    logic [1:0] OpAlu;
    logic       alu_fonte_a;
    logic [1:0] alu_fonte_b;
    logic [1:0] pc_fonte;
    logic       pc_escreve;
    logic       ir_escreve;
    logic       mem_le;
    logic       mem_escreve;
    logic       reg_escreve;
    logic       mem_para_reg;

    modport master (
        input  Opcode, Zero, mem_pronta,
        output OpAlu, alu_fonte_a, alu_fonte_b, pc_fonte, pc_escreve,
               ir_escreve, mem_le, mem_escreve, reg_escreve, mem_para_reg
    );

    modport slave (
        output Opcode, Zero, mem_pronta,
        input  OpAlu, alu_fonte_a, alu_fonte_b, pc_fonte, pc_escreve,
               ir_escreve, mem_le, mem_escreve, reg_escreve, mem_para_reg
    );
endinterface

// File: rtl/unidade_controle_multiciclo_temporizador_espera_mem.sv
// temporizador_espera_mem: counts consecutive cycles a memory wait state
// spends without mem_pronta and flags the cycle in which the limit is hit.
//   clock, reset : clock, async active-high reset
//   ativo        : FSM is in a memory wait state
//   mem_pronta   : memory ready this cycle
//   muda_estado  : FSM leaves its current state on the next edge
//   estouro      : limit reached this cycle with no mem_pronta
module temporizador_espera_mem #(
    parameter int TIMEOUT_MEM = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic ativo,
    input  logic mem_pronta,
    input  logic muda_estado,
    output logic estouro
);
    localparam int LARG = $clog2(TIMEOUT_MEM + 1);
    // The counter holds the number of cycles already waited, so the limit
    // is hit while it still shows TIMEOUT_MEM-1 and this cycle is waiting too.
    localparam logic [LARG-1:0] LIMITE = LARG'(TIMEOUT_MEM - 1);

    logic [LARG-1:0] cont;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cont <= '0;
        else if (!ativo || mem_pronta || muda_estado)
            cont <= '0;
        else
            cont <= cont + 1'b1;
    end

    assign estouro = ativo && !mem_pronta && (cont == LIMITE);
endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multi-cycle main control FSM. Sequences
// fetch/decode/execute/memory/writeback, drives ALU class and datapath
// selects/enables, times out stalled memory handshakes, counts retired
// instructions and keeps sticky error flags.
//   clock, reset : clock, async active-high reset
//   bus          : datapath/memory control bundle (master side)
//   estado       : current state encoding
//   instrucoes   : retired instruction count (wraps)
//   parado       : FSM is halted
//   erro_opcode  : illegal opcode decoded (sticky)
//   erro_mem     : memory wait timed out (sticky)
module unidade_controle_multiciclo
    import controle_pkg::*;
#(
    parameter int TIMEOUT_MEM  = 255,
    parameter int LARGURA_CONT = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    unidade_controle_multiciclo_if.master bus,
    output logic [3:0]              estado,
    output logic [LARGURA_CONT-1:0] instrucoes,
    output logic                    parado,
    output logic                    erro_opcode,
    output logic                    erro_mem
);
    estado_t atual, prox;
    ctrl_t   c;
    logic    retira, seta_erro_op, seta_erro_mem;
    logic    espera, estouro;

    assign espera = (atual == BUSCA) || (atual == LE_MEM) || (atual == GRAVA_MEM);

    temporizador_espera_mem #(.TIMEOUT_MEM(TIMEOUT_MEM)) u_temporizador (
        .clock       (clock),
        .reset       (reset),
        .ativo       (espera),
        .mem_pronta  (bus.mem_pronta),
        .muda_estado (prox != atual),
        .estouro     (estouro)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            atual       <= BUSCA;
            instrucoes  <= '0;
            erro_opcode <= 1'b0;
            erro_mem    <= 1'b0;
        end else begin
            atual <= prox;
            if (retira)        instrucoes  <= instrucoes + 1'b1;
            if (seta_erro_op)  erro_opcode <= 1'b1;
            if (seta_erro_mem) erro_mem    <= 1'b1;
        end
    end

    always_comb begin
        prox          = atual;
        c             = '0;
        retira        = 1'b0;
        seta_erro_op  = 1'b0;
        seta_erro_mem = 1'b0;
        case (atual)
            BUSCA: begin
                c.mem_le      = 1'b1;
                c.alu_fonte_b = FB_UM;
                c.op_alu      = ALU_SOMA;
                c.pc_fonte    = PC_ALU;
                // IR load and PC+1 happen on the edge the fetch completes.
                c.ir_escreve  = bus.mem_pronta;
                c.pc_escreve  = bus.mem_pronta;
                if (bus.mem_pronta)
                    prox = DECODIFICA;
                else if (estouro) begin
                    prox          = PARADO;
                    seta_erro_mem = 1'b1;
                end
            end
            DECODIFICA: begin
                // Branch target is precomputed into ALUOut here.
                c.alu_fonte_b = FB_DESVIO;
                c.op_alu      = ALU_SOMA;
                if (eh_op_alu(bus.Opcode))
                    prox = EXEC_R;
                else begin
                    case (bus.Opcode)
                        OP_LOAD, OP_STORE: prox = CALC_END;
                        OP_BEQ:            prox = DESVIO;
                        OP_JUMP:           prox = SALTO;
                        OP_NOP: begin
                            prox   = BUSCA;
                            retira = 1'b1;
                        end
                        OP_HALT: begin
                            prox   = PARADO;
                            retira = 1'b1;
                        end
                        default: begin
                            prox         = PARADO;
                            seta_erro_op = 1'b1;
                        end
                    endcase
                end
            end
            EXEC_R: begin
                c.alu_fonte_a = 1'b1;
                c.alu_fonte_b = FB_REG_B;
                c.op_alu      = ALU_FUNC;
                prox          = ESCRITA_R;
            end
            ESCRITA_R: begin
                c.reg_escreve = 1'b1;
                prox          = BUSCA;
                retira        = 1'b1;
            end
            CALC_END: begin
                c.alu_fonte_a = 1'b1;
                c.alu_fonte_b = FB_IMED;
                c.op_alu      = ALU_SOMA;
                prox          = (bus.Opcode == OP_LOAD) ? LE_MEM : GRAVA_MEM;
            end
            LE_MEM: begin
                c.mem_le = 1'b1;
                if (bus.mem_pronta)
                    prox = ESCRITA_MEM;
                else if (estouro) begin
                    prox          = PARADO;
                    seta_erro_mem = 1'b1;
                end
            end
            ESCRITA_MEM: begin
                c.reg_escreve  = 1'b1;
                c.mem_para_reg = 1'b1;
                prox           = BUSCA;
                retira         = 1'b1;
            end
            GRAVA_MEM: begin
                c.mem_escreve = 1'b1;
                if (bus.mem_pronta) begin
                    prox   = BUSCA;
                    retira = 1'b1;
                end else if (estouro) begin
                    prox          = PARADO;
                    seta_erro_mem = 1'b1;
                end
            end
            DESVIO: begin
                c.alu_fonte_a = 1'b1;
                c.alu_fonte_b = FB_REG_B;
                c.op_alu      = ALU_SUB;
                c.pc_fonte    = PC_ALUOUT;
                c.pc_escreve  = bus.Zero;
                prox          = BUSCA;
                retira        = 1'b1;
            end
            SALTO: begin
                c.pc_fonte   = PC_SALTO;
                c.pc_escreve = 1'b1;
                prox         = BUSCA;
                retira       = 1'b1;
            end
            PARADO: c.parado = 1'b1;
            default: prox = PARADO;
        endcase
        // Reset state is BUSCA, whose outputs would otherwise request a fetch.
        if (reset) c = '0;
    end

    assign bus.OpAlu        = c.op_alu;
    assign bus.alu_fonte_a  = c.alu_fonte_a;
    assign bus.alu_fonte_b  = c.alu_fonte_b;
    assign bus.pc_fonte     = c.pc_fonte;
    assign bus.pc_escreve   = c.pc_escreve;
    assign bus.ir_escreve   = c.ir_escreve;
    assign bus.mem_le       = c.mem_le;
    assign bus.mem_escreve  = c.mem_escreve;
    assign bus.reg_escreve  = c.reg_escreve;
    assign bus.mem_para_reg = c.mem_para_reg;
    assign parado           = c.parado;
    assign estado           = atual;
endmodule
